apb_req_arbiter: RTL and testbench

Round-robin APB master front-end that shares one APB bus, typically a bank of APB register files, between `NoReqs` independent requesters. Each requester issues a simple valid/ready transfer request. The block grants one request at a time and drives the full APB SETUP/ACCESS protocol. It returns read data and error status to the granted requester in the completion cycle.

---
 rtl/apb_req_arbiter.sv | 140 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin front-end that shares one APB master port between
// NoReqs valid/ready requesters, running one IDLE/SETUP/ACCESS transfer at a time.
module apb_req_arbiter #(
   parameter int  NoReqs    = 4,
   parameter int  AddrWidth = 32,
   parameter int  DataWidth = 32,
   localparam int StrbWidth = (DataWidth + 7) / 8,
   localparam int IdxWidth  = (NoReqs > 1) ? $clog2(NoReqs) : 1
) (
   input  logic                           pclk_i,
   input  logic                           preset_ni,
   input  logic [NoReqs-1:0]              req_valid_i,
   output logic [NoReqs-1:0]              req_ready_o,
   input  logic [NoReqs*AddrWidth-1:0]    req_addr_i,
   input  logic [NoReqs-1:0]              req_write_i,
   input  logic [NoReqs*DataWidth-1:0]    req_wdata_i,
   input  logic [NoReqs*StrbWidth-1:0]    req_strb_i,
   output logic [DataWidth-1:0]           rsp_rdata_o,
   output logic                           rsp_slverr_o,
   output logic [AddrWidth-1:0]           paddr_o,
   output logic                           pwrite_o,
   output logic [DataWidth-1:0]           pwdata_o,
   output logic [StrbWidth-1:0]           pstrb_o,
   output logic                           psel_o,
   output logic                           penable_o,
   output logic [2:0]                     pprot_o,
   input  logic                           pready_i,
   input  logic [DataWidth-1:0]           prdata_i,
   input  logic                           pslverr_i
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   state_e                state_q, state_d;
   logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IdxWidth-1:0]   idx_q;
   logic [IdxWidth-1:0]   win_idx, cand;
   logic                  win_found;
   logic [AddrWidth-1:0]  addr_q;
   logic                  write_q;
   logic [DataWidth-1:0]  wdata_q;
   logic [StrbWidth-1:0]  strb_q;
   logic                  psel_q, penable_q;

   logic [AddrWidth-1:0]  req_addr  [NoReqs];
   logic [DataWidth-1:0]  req_wdata [NoReqs];
   logic [StrbWidth-1:0]  req_strb  [NoReqs];

   always_comb begin
      for (int n = 0; n < NoReqs; n++) begin
         req_addr[n]  = req_addr_i[n*AddrWidth +: AddrWidth];
         req_wdata[n] = req_wdata_i[n*DataWidth +: DataWidth];
         req_strb[n]  = req_strb_i[n*StrbWidth +: StrbWidth];
      end
   end

   // Search upward from rr_ptr with wrap-around; first pending requester wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves
      // it unassigned, which is what would otherwise infer a latch.
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NoReqs; i++) begin
         cand = IdxWidth'((int'(rr_ptr_q) + i) % NoReqs);
         if (!win_found && req_valid_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      req_ready_o = '0;
      unique case (state_q)
         IDLE: begin
            if (win_found) state_d = SETUP;
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (pready_i) begin
               req_ready_o[idx_q] = 1'b1;
               rr_ptr_d = (idx_q == IdxWidth'(NoReqs - 1)) ? '0 : idx_q + 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the latched payload registers are reset as well, because the APB
   // outputs are driven straight from them and must read zero out of reset.
   always_ff @(posedge pclk_i or negedge preset_ni) begin
      if (!preset_ni) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         idx_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         psel_q    <= (state_d != IDLE);
         penable_q <= (state_d == ACCESS);
         if (state_q == IDLE && win_found) begin
            idx_q   <= win_idx;
            addr_q  <= req_addr[win_idx];
            write_q <= req_write_i[win_idx];
            wdata_q <= req_wdata[win_idx];
            strb_q  <= req_write_i[win_idx] ? req_strb[win_idx] : '0;
         end
      end
   end

   assign paddr_o      = addr_q;
   assign pwrite_o     = write_q;
   assign pwdata_o     = wdata_q;
   assign pstrb_o      = strb_q;
   assign psel_o       = psel_q;
   assign penable_o    = penable_q;
   assign pprot_o      = 3'b000;
   assign rsp_rdata_o  = prdata_i;
   assign rsp_slverr_o = pslverr_i;

   // A requester must hold valid until it sees its ready pulse.
   for (genvar n = 0; n < NoReqs; n++) begin : g_hold_chk
      a_valid_held: assert property (@(posedge pclk_i) disable iff (!preset_ni)
         (req_valid_i[n] && !req_ready_o[n]) |=> req_valid_i[n]);
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: bench-side APB slave model, scoreboard
// of expected completions, directed timing checks and a NoReqs=1 instance.
module tb_apb_req_arbiter;

   logic clk;
   logic rst_n;

   // Four-requester instance.
   logic [3:0]   req_valid, req_ready, req_write;
   logic [127:0] req_addr, req_wdata;
   logic [15:0]  req_strb;
   logic [31:0]  rsp_rdata, paddr, pwdata, prdata;
   logic         rsp_slverr, pwrite, psel, penable, pready, pslverr;
   logic [3:0]   pstrb;
   logic [2:0]   pprot;

   // Single-requester, 1-bit-data instance.
   logic         b_valid, b_ready, b_write, b_wdata, b_strb, b_rdata, b_slverr;
   logic [31:0]  b_addr, b_paddr;
   logic         b_pwrite, b_pwdata, b_pstrb, b_psel, b_penable;
   logic [2:0]   b_pprot;
   logic         b_pready, b_prdata, b_pslverr;

   typedef struct {
      logic [1:0]  idx;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   slv_waits = 0;
   int   wait_left = 0;

   apb_req_arbiter #(.NoReqs(4), .AddrWidth(32), .DataWidth(32)) dut (
      .pclk_i(clk), .preset_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_addr_i(req_addr), .req_write_i(req_write),
      .req_wdata_i(req_wdata), .req_strb_i(req_strb),
      .rsp_rdata_o(rsp_rdata), .rsp_slverr_o(rsp_slverr),
      .paddr_o(paddr), .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
      .psel_o(psel), .penable_o(penable), .pprot_o(pprot),
      .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
   );

   apb_req_arbiter #(.NoReqs(1), .AddrWidth(32), .DataWidth(1)) dut_b (
      .pclk_i(clk), .preset_ni(rst_n),
      .req_valid_i(b_valid), .req_ready_o(b_ready),
      .req_addr_i(b_addr), .req_write_i(b_write),
      .req_wdata_i(b_wdata), .req_strb_i(b_strb),
      .rsp_rdata_o(b_rdata), .rsp_slverr_o(b_slverr),
      .paddr_o(b_paddr), .pwrite_o(b_pwrite), .pwdata_o(b_pwdata), .pstrb_o(b_pstrb),
      .psel_o(b_psel), .penable_o(b_penable), .pprot_o(b_pprot),
      .pready_i(b_pready), .prdata_i(b_prdata), .pslverr_i(b_pslverr)
   );

   // Zero-wait slave for the single-requester instance; data is address LSB.
   assign b_pready  = b_penable;
   assign b_prdata  = b_paddr[0];
   assign b_pslverr = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] slave_rdata(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEAD_BEEF : ~a;
   endfunction

   function automatic logic slave_err(input logic [31:0] a);
      return (a[7:4] == 4'hE);
   endfunction

   function automatic exp_t mk_exp(input int n, input logic [31:0] addr, input logic write,
                                   input logic [31:0] wdata, input logic [3:0] strb);
      exp_t e;
      e.idx   = 2'(n);
      e.addr  = addr;
      e.write = write;
      e.wdata = wdata;
      e.strb  = strb;
      e.rdata = slave_rdata(addr);
      e.err   = slave_err(addr);
      return e;
   endfunction

   function automatic exp_t traffic(input int n, input int s);
      return mk_exp(n, 32'h100 + 32'(n * 32 + s * 4), 1'((n + s) % 2),
                    32'hC0DE_0000 + 32'(n * 256 + s), 4'(n + s + 1));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic apply(input exp_t e);
      req_addr[int'(e.idx)*32 +: 32]  = e.addr;
      req_wdata[int'(e.idx)*32 +: 32] = e.wdata;
      req_strb[int'(e.idx)*4 +: 4]    = e.strb;
      req_write[e.idx]                = e.write;
   endtask

   // APB slave: inserts slv_waits wait states per transfer, then answers from its model.
   always @(posedge clk) begin
      #1;
      if (psel && penable) begin
         if (wait_left > 0) begin
            pready  = 1'b0;
            prdata  = $urandom;
            pslverr = 1'b0;
            wait_left--;
         end else begin
            pready  = 1'b1;
            prdata  = slave_rdata(paddr);
            pslverr = slave_err(paddr);
         end
      end else begin
         pready    = 1'b0;
         prdata    = $urandom;
         pslverr   = 1'b0;
         wait_left = slv_waits;
      end
   end

   // Completion monitor: every ready pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (req_ready != 4'b0000) begin
         check("ready_onehot", $countones(req_ready), 1);
         if (sb_q.size() == 0) begin
            check("ready_unexpected", req_ready, 4'b0000);
         end else begin
            mon_e = sb_q.pop_front();
            check("grant_idx", req_ready, 4'b0001 << mon_e.idx);
            check("rsp_rdata", rsp_rdata, mon_e.rdata);
            check("rsp_slverr", rsp_slverr, mon_e.err);
            check("apb_paddr", paddr, mon_e.addr);
            check("apb_pwrite", pwrite, mon_e.write);
            check("apb_pwdata", pwdata, mon_e.wdata);
            check("apb_pstrb", pstrb, mon_e.write ? mon_e.strb : 4'h0);
         end
      end
   end

   task automatic do_single(input exp_t e, output logic err_seen);
      bit got = 1'b0;
      err_seen = 1'b0;
      sb_q.push_back(e);
      step();
      apply(e);
      req_valid[e.idx] = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         if (c > 0) step();
         sample();
         if (req_ready[e.idx]) begin
            got      = 1'b1;
            err_seen = rsp_slverr;
         end
      end
      check("single_done", got, 1);
      step();
      req_valid[e.idx] = 1'b0;
   endtask

   // All four requesters stay valid, each issuing per_req transfers back to back.
   task automatic run_traffic(input int per_req, output int cycles);
      int         seq [4];
      int         served;
      logic [3:0] done;
      for (int s = 0; s < per_req; s++)
         for (int n = 0; n < 4; n++) sb_q.push_back(traffic(n, s));
      step();
      for (int n = 0; n < 4; n++) begin
         seq[n] = 0;
         apply(traffic(n, 0));
      end
      req_valid = 4'hF;
      served = 0;
      cycles = 0;
      while (served < 4 * per_req && cycles < 200) begin
         sample();
         done = req_ready;
         served += $countones(req_ready);
         cycles++;
         step();
         for (int n = 0; n < 4; n++) begin
            if (done[n]) begin
               seq[n]++;
               if (seq[n] < per_req) apply(traffic(n, seq[n]));
               else req_valid[n] = 1'b0;
            end
         end
      end
      check("traffic_served", served, 4 * per_req);
   endtask

   initial begin
      exp_t e;
      logic err_seen;
      int   cyc, pen_cnt, ready_cyc, b_cnt, b_first, b_last;
      bit   stable_ok, b_ok, b_gap_ok, t2_done;

      rst_n     = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_strb  = '0;
      pready    = 1'b0;
      prdata    = '0;
      pslverr   = 1'b0;
      b_valid   = 1'b0;
      b_write   = 1'b0;
      b_wdata   = 1'b0;
      b_strb    = 1'b0;
      b_addr    = '0;

      // Reset state.
      sample();
      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_pwrite", pwrite, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_pstrb", pstrb, 0);
      check("rst_ready", req_ready, 0);
      check("rst_pprot", pprot, 0);
      check("rst_b_psel", b_psel, 0);
      step();
      rst_n = 1'b1;

      // Single read, zero wait states.
      slv_waits = 0;
      e = mk_exp(0, 32'h10, 1'b0, 32'h0, 4'hF);
      sb_q.push_back(e);
      step();
      apply(e);
      req_valid[0] = 1'b1;
      sample();
      check("t1_c0_psel", psel, 0);
      step();
      sample();
      check("t1_setup_psel", psel, 1);
      check("t1_setup_penable", penable, 0);
      check("t1_setup_paddr", paddr, 32'h10);
      step();
      sample();
      check("t1_access_penable", penable, 1);
      check("t1_ready", req_ready, 4'b0001);
      check("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("t1_slverr", rsp_slverr, 0);
      step();
      req_valid[0] = 1'b0;
      sample();
      check("t1_idle_psel", psel, 0);

      // Write with three wait states.
      slv_waits = 3;
      e = mk_exp(2, 32'h8, 1'b1, 32'h1234_5678, 4'hF);
      sb_q.push_back(e);
      step();
      apply(e);
      req_valid[2] = 1'b1;
      sample();
      pen_cnt   = 0;
      ready_cyc = -1;
      stable_ok = 1'b1;
      t2_done   = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         step();
         if (t2_done) req_valid[2] = 1'b0;
         sample();
         if (penable) pen_cnt++;
         if (psel && (paddr !== 32'h8 || pwdata !== 32'h1234_5678 || pstrb !== 4'hF))
            stable_ok = 1'b0;
         if (req_ready != 4'b0000) begin
            check("t2_ready_val", req_ready, 4'b0100);
            ready_cyc = c;
            t2_done   = 1'b1;
         end
      end
      check("t2_penable_cycles", pen_cnt, 4);
      check("t2_ready_cycle", ready_cyc, 5);
      check("t2_payload_stable", stable_ok, 1);

      // Slave error on requester 3 (pointer then wraps to 0).
      slv_waits = 1;
      do_single(mk_exp(3, 32'hE0, 1'b0, 32'h55, 4'h3), err_seen);
      check("t4_slverr", err_seen, 1);

      // Round robin, all requesters continuously pending.
      slv_waits = 0;
      run_traffic(2, cyc);
      check("t3_cycles", cyc, 24);

      // Reset in the middle of a waited ACCESS.
      do_single(mk_exp(1, 32'h40, 1'b1, 32'hABCD, 4'h6), err_seen);
      slv_waits = 5;
      step();
      apply(mk_exp(2, 32'h44, 1'b0, 32'h9, 4'h1));
      req_valid[2] = 1'b1;
      sample();
      step();
      sample();
      step();
      sample();
      check("t5_in_access", penable, 1);
      #1 rst_n = 1'b0;
      #1;
      check("t5_async_psel", psel, 0);
      check("t5_async_penable", penable, 0);
      check("t5_async_paddr", paddr, 0);
      check("t5_async_pstrb", pstrb, 0);
      req_valid = '0;
      for (int c = 0; c < 2; c++) begin
         step();
         sample();
         check("t5_rst_ready", req_ready, 0);
      end
      step();
      rst_n     = 1'b1;
      slv_waits = 0;
      run_traffic(1, cyc);
      check("t5_cycles", cyc, 12);

      // Single requester, 1-bit data: back-to-back reads.
      step();
      b_valid  = 1'b1;
      b_addr   = 32'h3;
      b_write  = 1'b0;
      b_wdata  = 1'b1;
      b_strb   = 1'b1;
      b_cnt    = 0;
      b_first  = -1;
      b_last   = -1;
      b_ok     = 1'b1;
      b_gap_ok = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) step();
         sample();
         if (b_psel && (b_pstrb !== 1'b0 || b_pwrite !== 1'b0 || b_pwdata !== 1'b1 ||
                        b_paddr !== 32'h3))
            b_ok = 1'b0;
         if (b_ready) begin
            check("t6_rdata", b_rdata, 1);
            check("t6_slverr", b_slverr, 0);
            if (b_last >= 0 && c - b_last != 3) b_gap_ok = 1'b0;
            if (b_first < 0) b_first = c;
            b_last = c;
            b_cnt++;
         end
      end
      step();
      b_valid = 1'b0;
      check("t6_count", b_cnt, 4);
      check("t6_first", b_first, 2);
      check("t6_spacing", b_gap_ok, 1);
      check("t6_apb_fields", b_ok, 1);

      step();
      check("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
